// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types and widths for the two-requester ALU sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam int SEL_W = 4;
    localparam int OPD_W = 2;
    localparam int RES_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [SEL_W-1:0] s;
        logic             m;
        logic [OPD_W-1:0] a;
        logic [OPD_W-1:0] b;
    } op_t;

    function automatic op_t make_op(
        input logic [SEL_W-1:0] s,
        input logic             m,
        input logic [OPD_W-1:0] a,
        input logic [OPD_W-1:0] b
    );
        op_t o;
        o.s = s;
        o.m = m;
        o.a = a;
        o.b = b;
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter; one-hot grant, purely combinational.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Arbitrates two requesters onto an external combinational ALU,
//               holds its inputs for SETTLE_CYCLES and returns the result.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [SEL_W-1:0] req0_s,
    input  logic             req0_m,
    input  logic [OPD_W-1:0] req0_a,
    input  logic [OPD_W-1:0] req0_b,
    input  logic [SEL_W-1:0] req1_s,
    input  logic             req1_m,
    input  logic [OPD_W-1:0] req1_a,
    input  logic [OPD_W-1:0] req1_b,

    output logic [SEL_W-1:0] alu_s,
    output logic             alu_m,
    output logic [OPD_W-1:0] alu_a,
    output logic [OPD_W-1:0] alu_b,
    input  logic [RES_W-1:0] alu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [RES_W-1:0] rsp_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    op_t              op_q, op_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;

    logic [1:0]       grant;
    logic             arb_en;
    logic             accept;
    op_t              req0_op;
    op_t              req1_op;
    op_t              sel_op;

    assign req0_op = make_op(req0_s, req0_m, req0_a, req0_b);
    assign req1_op = make_op(req1_s, req1_m, req1_a, req1_b);

    // Gating with rst_n keeps req_ready low while reset is held, even if a
    // requester keeps its valid asserted through the reset.
    assign arb_en = (state_q == IDLE) && rst_n;

    rr_arbiter_2 u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (arb_en),
        .grant      (grant)
    );

    assign accept = |(req_valid & grant);
    assign sel_op = grant[1] ? req1_op : req0_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DRIVE;
            DRIVE:   if (cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = grant;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    // Datapath next-state: op latch, settle counter, result capture, fairness.
    always_comb begin
        op_d         = op_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = sel_op;
                    id_d  = grant[1];
                    cnt_d = SETTLE_LOAD;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    rsp_data_d = alu_out;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else begin
            op_q         <= op_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // ALU inputs come straight from the op register so they never glitch.
    assign alu_s    = op_q.s;
    assign alu_m    = op_q.m;
    assign alu_a    = op_q.a;
    assign alu_b    = op_q.b;
    assign rsp_id   = id_q;
    assign rsp_data = rsp_data_q;

endmodule

`default_nettype wire
